// File: rtl/spi_pkg.sv
// Shared SPI definitions for the spi_fsm master and the spi_slave_rx receiver.
//   spi_rx_state_t : receiver FSM states (IDLE, RECV)
//   SPI_CPOL/SPI_CPHA/SPI_MSB_FIRST : link mode, mode 0 with MSB first
package spi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } spi_rx_state_t;

   localparam bit SPI_CPOL      = 1'b0;
   localparam bit SPI_CPHA      = 1'b0;
   localparam bit SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Input synchroniser for one asynchronous SPI pin.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pin
//   level    : synchronised level (SYNC_STAGES flops deep)
//   rise     : level went 0 -> 1 this cycle
//   fall     : level went 1 -> 0 this cycle
// RST_VAL is the pin's idle level, so reset never manufactures an edge.
module spi_sync
   import spi_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   prev_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= {SYNC_STAGES{RST_VAL}};
         prev_p1 <= RST_VAL;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
         prev_p1 <= sync_p0[SYNC_STAGES-1];
      end
   end

   assign level = sync_p0[SYNC_STAGES-1];
   assign rise  = level & ~prev_p1;
   assign fall  = ~level & prev_p1;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, MSB first.
//   clk, rst   : system clock, synchronous active-high reset
//   sclk, cs, mosi : asynchronous SPI pins (cs active low, sclk idles low)
//   rx_data    : last received word, MSB = first bit on the wire
//   rx_valid   : rx_data holds an unconsumed word
//   rx_ready   : consumer takes the word when rx_valid && rx_ready
//   busy       : receiver is inside a frame
//   overrun    : 1-clk pulse, completed word dropped (previous one unconsumed)
//   frame_err  : 1-clk pulse, cs rose with a partial word
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              overrun,
   output logic              frame_err
);

   localparam int CNT_W   = $clog2(DATA_W + 1);
   localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

   logic sclk_rise, cs_s, cs_rise, cs_fall, mosi_s;
   logic sclk_lvl_unused, sclk_fall_unused, mosi_rise_unused, mosi_fall_unused;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(sclk),
      .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
   );

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .din(cs),
      .level(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(mosi),
      .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_rx_state_t     state, state_n;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
   logic [DATA_W-1:0] shift, shift_n, shift_in;
   logic              word_done, frame_err_n;
   logic              armed;
   logic [FLUSH_W-1:0] flush_cnt;
   logic              flush_done;

   assign shift_in = {shift[DATA_W-2:0], mosi_s};

   // The cs synchroniser comes out of reset showing its reset value (high),
   // not the pin. Until that reset value has been flushed, cs_s must not arm
   // the receiver, otherwise a reset in mid-frame would rejoin that frame.
   assign flush_done = (flush_cnt == FLUSH_W'(SYNC_STAGES));

   // Sample/shift stage: next-state decode. The sclk edge is applied before
   // cs_rise so a word completed on the final edge is delivered, not flagged.
   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift;
      word_done   = 1'b0;
      frame_err_n = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall && armed) begin
               state_n   = RECV;
               bit_cnt_n = '0;
            end
         end
         RECV: begin
            if (sclk_rise) begin
               shift_n = shift_in;
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  word_done = 1'b1;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt + CNT_W'(1);
               end
            end
            if (cs_rise) begin
               state_n = IDLE;
               if (bit_cnt_n != '0) frame_err_n = 1'b1;
               bit_cnt_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Register stage: FSM state, shifter, output word and handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         armed     <= 1'b0;
         flush_cnt <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         frame_err <= frame_err_n;
         overrun   <= 1'b0;
         if (!flush_done) flush_cnt <= flush_cnt + FLUSH_W'(1);
         if (cs_s && flush_done) armed <= 1'b1;
         if (word_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift_in;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state == RECV);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: directed SPI frames, expected words queued at
// issue time and compared by a monitor whenever a word is accepted.
module tb_spi_slave_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk, cs, mosi;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready, busy, overrun, frame_err;

   int errors = 0;
   int checks = 0;
   int ovr_cnt = 0;
   int ferr_cnt = 0;
   int ovr_base, ferr_base;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .overrun(overrun), .frame_err(frame_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic open_frame();
      cs = 1'b0;
      tick(4);
   endtask

   task automatic close_frame();
      tick(4);
      cs = 1'b1;
      tick(8);
   endtask

   // Sends the top n bits of w, MSB first, sclk half period = 4 clk.
   // With trick set, rx_ready is raised so that it is high exactly in the
   // clock where the last bit's word completes.
   task automatic send_bits(input logic [7:0] w, input int n, input bit trick);
      logic [7:0] wv;
      wv = w;
      for (int i = 0; i < n; i++) begin
         mosi = wv[7-i];
         tick(4);
         sclk = 1'b1;
         if (trick && i == n - 1) begin
            tick(2);
            rx_ready = 1'b1;
            tick(1);
            check("same_clk_valid", rx_valid, 1);
            check("same_clk_data", rx_data, wv);
            tick(1);
         end else begin
            tick(4);
         end
         sclk = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; rx_ready = 1'b1;
      fork
         // Monitor: compares on every accepted word, counts error pulses.
         begin
            forever begin
               @(negedge clk);
               if (rx_valid && rx_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_word: got %0h, expected none", rx_data);
                  end else begin
                     logic [7:0] e;
                     e = exp_q.pop_front();
                     if (rx_data !== e) begin
                        errors++;
                        $display("FAIL word: got %0h, expected %0h", rx_data, e);
                     end
                  end
               end
               if (overrun) ovr_cnt++;
               if (frame_err) ferr_cnt++;
            end
         end
         // Watchdog.
         begin
            repeat (50000) @(posedge clk);
            checks++;
            errors++;
            $display("FAIL timeout: got running, expected finished");
         end
         // Stimulus.
         begin
            tick(4);
            check("rst_valid", rx_valid, 0);
            check("rst_data", rx_data, 0);
            check("rst_busy", busy, 0);
            check("rst_overrun", overrun, 0);
            check("rst_frame_err", frame_err, 0);
            rst = 1'b0;
            tick(8);

            // 1: single word
            exp_q.push_back(8'hEF);
            open_frame();
            check("t1_busy_in_frame", busy, 1);
            send_bits(8'hEF, 8, 1'b0);
            close_frame();
            check("t1_busy_after", busy, 0);
            check("t1_drained", exp_q.size(), 0);
            check("t1_overrun", ovr_cnt, 0);
            check("t1_frame_err", ferr_cnt, 0);

            // 2: two words in one frame
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h3C);
            open_frame();
            send_bits(8'hA5, 8, 1'b0);
            send_bits(8'h3C, 8, 1'b0);
            close_frame();
            check("t2_drained", exp_q.size(), 0);
            check("t2_frame_err", ferr_cnt, 0);

            // 3: short frame then a good one
            open_frame();
            send_bits(8'hF0, 5, 1'b0);
            close_frame();
            check("t3_frame_err", ferr_cnt, 1);
            check("t3_valid", rx_valid, 0);
            exp_q.push_back(8'h81);
            open_frame();
            send_bits(8'h81, 8, 1'b0);
            close_frame();
            check("t3_drained", exp_q.size(), 0);
            check("t3_frame_err_once", ferr_cnt, 1);

            // 4: overrun while consumer stalls
            rx_ready = 1'b0;
            exp_q.push_back(8'h11);
            open_frame();
            send_bits(8'h11, 8, 1'b0);
            send_bits(8'h22, 8, 1'b0);
            close_frame();
            check("t4_data", rx_data, 8'h11);
            check("t4_valid", rx_valid, 1);
            check("t4_overrun", ovr_cnt, 1);
            rx_ready = 1'b1;
            tick(1);
            check("t4_valid_dropped", rx_valid, 0);
            check("t4_drained", exp_q.size(), 0);

            // 5: accept and complete in the same clock
            rx_ready = 1'b0;
            exp_q.push_back(8'hC3);
            exp_q.push_back(8'h96);
            open_frame();
            send_bits(8'hC3, 8, 1'b0);
            send_bits(8'h96, 8, 1'b1);
            close_frame();
            check("t5_overrun", ovr_cnt, 1);
            check("t5_drained", exp_q.size(), 0);

            // 6: reset in mid-frame, remainder ignored
            ovr_base = ovr_cnt;
            ferr_base = ferr_cnt;
            open_frame();
            send_bits(8'hE0, 3, 1'b0);
            rst = 1'b1;
            tick(2);
            rst = 1'b0;
            check("t6_rst_valid", rx_valid, 0);
            check("t6_rst_data", rx_data, 0);
            check("t6_rst_busy", busy, 0);
            send_bits(8'hFF, 8, 1'b0);
            check("t6_ignored_busy", busy, 0);
            check("t6_ignored_valid", rx_valid, 0);
            close_frame();
            check("t6_no_ferr", ferr_cnt, ferr_base);
            check("t6_no_ovr", ovr_cnt, ovr_base);
            exp_q.push_back(8'h5A);
            open_frame();
            send_bits(8'h5A, 8, 1'b0);
            close_frame();
            check("t6_drained", exp_q.size(), 0);
            check("t6_ferr_final", ferr_cnt, ferr_base);
         end
      join_any
      disable fork;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
